// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit with HI/LO registers and MTHI/MTLO writes
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   hi_p, lo_p, hi_pn, lo_pn, hi_n, lo_n;
   logic          dz_p, dz_n;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   ua, ub, db, q, r, qs, rs, bu, qu, ru;

   assign busy  = cnt != '0;
   assign state = busy ? RUN : IDLE;

   assign prod_s = 64'($signed(A)) * 64'($signed(B));
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally
   assign ua = A[31] ? -A : A;
   assign ub = B[31] ? -B : B;
   assign db = (ub == '0) ? 32'd1 : ub;
   assign q  = ua / db;
   assign r  = ua % db;
   assign qs = (A[31] ^ B[31]) ? -q : q;
   assign rs = A[31] ? -r : r;
   assign bu = (B == '0) ? 32'd1 : B;
   assign qu = A / bu;
   assign ru = A % bu;

   always_comb begin
      hi_n  = HI;
      lo_n  = LO;
      cnt_n = cnt;
      hi_pn = hi_p;
      lo_pn = lo_p;
      dz_n  = dz_p;
      if (state == RUN) begin
         cnt_n = cnt - CW'(1);
         // a divide by zero runs its full latency but never commits
         if (cnt == CW'(1) && !dz_p) begin
            hi_n = hi_p;
            lo_n = lo_p;
         end
      end else if (start) begin
         if (!md_op[2]) begin
            cnt_n          = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            dz_n           = md_op[1] && (B == '0);
            {hi_pn, lo_pn} = (md_op[1:0] == 2'd0) ? prod_s :
                             (md_op[1:0] == 2'd1) ? prod_u :
                             (md_op[1:0] == 2'd2) ? {rs, qs} : {ru, qu};
         end
         hi_n = (md_op == 3'd4) ? A : HI;
         lo_n = (md_op == 3'd5) ? A : LO;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI   <= '0;
         LO   <= '0;
         cnt  <= '0;
         hi_p <= '0;
         lo_p <= '0;
         dz_p <= 1'b0;
      end else begin
         HI   <= hi_n;
         LO   <= lo_n;
         cnt  <= cnt_n;
         hi_p <= hi_pn;
         lo_p <= lo_pn;
         dz_p <= dz_n;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = '0;
   logic [31:0] A = '0, B = '0;
   logic        busy;
   logic [31:0] HI, LO;
   logic [31:0] hi_m, lo_m;
   int          checks = 0;
   int          errors = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // reference: plain 64-bit arithmetic, truncating division, dividend-signed remainder
   task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      logic [63:0] ua = {32'd0, a};
      logic [63:0] ub = {32'd0, b};
      logic [63:0] p;
      case (op)
         3'd0: begin p = 64'(sa * sb); {hi_m, lo_m} = p; end
         3'd1: begin p = ua * ub; {hi_m, lo_m} = p; end
         3'd2: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
         3'd3: if (b != 0) begin lo_m = 32'(ua / ub); hi_m = 32'(ua % ub); end
         3'd4: hi_m = a;
         3'd5: lo_m = a;
         default: ;
      endcase
   endtask

   function automatic int lat(input logic [2:0] op);
      return op < 2 ? 5 : op < 4 ? 10 : 0;
   endfunction

   // drive a one-cycle start; returns at the falling edge after the issue edge, operands scrambled
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; md_op = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0; md_op = 3'($urandom); A = $urandom; B = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", LO); end
      @(negedge clk); #2 reset = 1'b0;
      hi_m = 0; lo_m = 0;
   endtask

   task automatic test_mult;
      int n;
      issue(3'd0, 32'hFFFFFFFF, 32'd2); ref_op(3'd0, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d exp 5", n); end
      checks++; if (HI !== 32'hFFFFFFFF || HI !== hi_m) begin errors++; $display("FAIL mult_hi got %h exp %h", HI, hi_m); end
      checks++; if (LO !== 32'hFFFFFFFE || LO !== lo_m) begin errors++; $display("FAIL mult_lo got %h exp %h", LO, lo_m); end
   endtask

   task automatic test_multu;
      int n = 0;
      logic [31:0] oh = hi_m, ol = lo_m;
      issue(3'd1, 32'hFFFFFFFF, 32'd2); ref_op(3'd1, 32'hFFFFFFFF, 32'd2);
      while (busy === 1'b1 && n < 100) begin
         n++;
         checks++; if (HI !== oh || LO !== ol) begin errors++; $display("FAIL multu_hold got %h_%h exp %h_%h", HI, LO, oh, ol); end
         @(negedge clk);
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d exp 5", n); end
      checks++; if (HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_res got %h_%h exp 00000001_fffffffe", HI, LO); end
   endtask

   task automatic test_div;
      int n;
      issue(3'd2, 32'hFFFFFFF9, 32'd2); ref_op(3'd2, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d exp 10", n); end
      checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD || HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL div_res got %h_%h exp ffffffff_fffffffd", HI, LO); end
      issue(3'd3, 32'hFFFFFFF9, 32'd2); ref_op(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divu_cycles got %0d exp 10", n); end
      checks++; if (HI !== 32'h1 || LO !== 32'h7FFFFFFC || HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL divu_res got %h_%h exp 00000001_7ffffffc", HI, LO); end
   endtask

   task automatic test_div_zero;
      int n;
      issue(3'd4, 32'h1234, 32'h0); ref_op(3'd4, 32'h1234, 32'h0);
      checks++; if (busy !== 1'b0 || HI !== 32'h1234) begin errors++; $display("FAIL mthi got busy %b hi %h exp 0 00001234", busy, HI); end
      issue(3'd5, 32'h5678, 32'h0); ref_op(3'd5, 32'h5678, 32'h0);
      checks++; if (busy !== 1'b0 || LO !== 32'h5678) begin errors++; $display("FAIL mtlo got busy %b lo %h exp 0 00005678", busy, LO); end
      issue(3'd2, 32'd100, 32'd0); ref_op(3'd2, 32'd100, 32'd0);
      wait_idle(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divz_cycles got %0d exp 10", n); end
      checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin errors++; $display("FAIL divz_res got %h_%h exp 00001234_00005678", HI, LO); end
   endtask

   task automatic test_start_during_busy;
      int n;
      issue(3'd0, 32'd7, 32'd9); ref_op(3'd0, 32'd7, 32'd9);
      @(negedge clk);
      start = 1'b1; md_op = 3'd5; A = 32'hAAAA;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      checks++; if (n !== 3) begin errors++; $display("FAIL busy_ign_cycles got %0d exp 3", n); end
      checks++; if (HI !== hi_m || LO !== lo_m || LO !== 32'd63) begin errors++; $display("FAIL busy_ign_res got %h_%h exp %h_%h", HI, LO, hi_m, lo_m); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'd1, 32'h10000, 32'h10000); ref_op(3'd1, 32'h10000, 32'h10000);
      repeat (4) @(negedge clk);
      start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd3;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_commit_busy got %b exp 0", busy); end
      checks++; if (HI !== 32'h1 || LO !== 32'h0) begin errors++; $display("FAIL b2b_commit_res got %h_%h exp 00000001_00000000", HI, LO); end
      issue(3'd0, 32'd3, 32'hFFFFFFFD); ref_op(3'd0, 32'd3, 32'hFFFFFFFD);
      wait_idle(n);
      checks++; if (n !== 5 || HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL b2b_next got %0d %h_%h exp 5 %h_%h", n, HI, LO, hi_m, lo_m); end
   endtask

   task automatic test_edge;
      int n;
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF); ref_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      checks++; if (HI !== 32'h0 || LO !== 32'h80000000 || HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL div_ovf got %h_%h exp 00000000_80000000", HI, LO); end
      issue(3'd0, 32'h80000000, 32'h80000000); ref_op(3'd0, 32'h80000000, 32'h80000000);
      wait_idle(n);
      checks++; if (HI !== 32'h40000000 || LO !== 32'h0 || HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL mult_min got %h_%h exp 40000000_00000000", HI, LO); end
   endtask

   task automatic test_reset_mid;
      issue(3'd3, 32'd1000, 32'd7);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL rst_mid got busy %b %h_%h exp 0 0_0", busy, HI, LO); end
      #2 reset = 1'b0;
      hi_m = 0; lo_m = 0;
      repeat (12) @(negedge clk);
      checks++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL rst_nocommit got busy %b %h_%h exp 0 0_0", busy, HI, LO); end
   endtask

   task automatic test_random;
      int n;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
         issue(op, a, b); ref_op(op, a, b);
         wait_idle(n);
         checks++; if (n !== lat(op)) begin errors++; $display("FAIL rand%0d_cycles op %0d got %0d exp %0d", i, op, n, lat(op)); end
         checks++; if (HI !== hi_m || LO !== lo_m) begin errors++; $display("FAIL rand%0d_res op %0d a %h b %h got %h_%h exp %h_%h", i, op, a, b, HI, LO, hi_m, lo_m); end
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_multu;
      test_div;
      test_div_zero;
      test_start_during_busy;
      test_back_to_back;
      test_edge;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO registers, instantiated in the EX stage alongside the ALU and feeding the EX/MEM pipeline register through the mfhi/mflo path. It accepts a one-cycle start from EX-stage decode, holds `busy` for a fixed latency, then commits the 64-bit result to HI/LO. The hazard unit uses `busy` and `start` to stall later mult/div/mf/mt instructions in ID.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu.
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high. The polarity and synchronicity of this reset are fixed.
- `start`  in  1: issue pulse from EX decode, sampled on the rising edge.
- `md_op`  in  3: operation code. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO. Codes 6 and 7 are no-ops.
- `A`  in  32: rs operand, already forwarded.
- `B`  in  32: rt operand, already forwarded.
- `busy`  out  1: an operation is in flight.
- `HI`  out  32: HI register.
- `LO`  out  32: LO register.

## Operation
- Registered state:
  - `HI` and `LO`.
  - Pending result registers `hi_p` and `lo_p`.
  - Down-counter `cnt`, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - `busy` = (`cnt` != 0).
- States:
  - IDLE: `cnt` = 0.
  - RUN: `cnt` > 0.
- IDLE to RUN: `start` = 1 with `md_op` in 0..3.
  - Latch the 64-bit result of A, B into `hi_p`/`lo_p`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- RUN: `cnt` decrements every edge. On the edge where `cnt` = 1, `HI`←`hi_p`, `LO`←`lo_p`, and `cnt`→0 (back to IDLE).
- MTHI/MTLO in IDLE (`start` = 1, `md_op` = 4 or 5): `HI`←A or `LO`←A on that edge. Zero latency; `busy` is never asserted.
- `start` while `busy` = 1: ignored completely, no state change. The hazard unit guarantees this never happens in legal operation.
- Arithmetic:
  - MULT: signed 32×32→64. HI = product[63:32], LO = product[31:0].
  - MULTU: unsigned 32×32→64, same HI/LO split.
  - DIV: signed. LO = quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - DIVU: unsigned, same HI/LO assignment.
  - B = 0 for div/divu: HI/LO are left unchanged at completion. The full DIV_CYCLES busy period still elapses.
- HI/LO must keep their old values throughout RUN. They change only on the commit edge.
- `md_op` codes 6 and 7 with `start` = 1: no effect.

## Timing
- Reset (asynchronous, immediate): `HI` = 0, `LO` = 0, `cnt` = 0, `busy` = 0. An in-flight operation is abandoned with no commit.
- `start` sampled at edge k for a mult:
  - `busy` = 1 after edges k through k+4.
  - At edge k+5, `busy` falls and the new HI/LO become visible in the same cycle.
  - Div follows the same pattern with 10 cycles.
- Back-to-back issue: a `start` sampled on the commit edge is ignored, because `busy` is still 1 in that cycle. The earliest new issue is the first cycle with `busy` = 0.
- Operands are captured only on the issue edge. Changes to A/B during RUN have no effect.
- Reset deasserted mid-cycle: the next rising edge operates normally from IDLE.

## Test plan
- MULT: A = 0xFFFFFFFF, B = 2 → `busy` high for exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU: same operands → HI = 0x00000001, LO = 0xFFFFFFFE. HI/LO hold their previous values until the commit edge.
- DIV and DIVU:
  - DIV A = 0xFFFFFFF9 (−7), B = 2 → `busy` high for 10 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU with the same operands → LO = 0x7FFFFFFC, HI = 0x00000001.
- Divide by zero: preload with MTHI 0x1234 then MTLO 0x5678. Issue DIV with B = 0 → busy for 10 cycles; HI/LO still 0x1234/0x5678 afterwards.
  - MTHI/MTLO take effect the edge after issue, with `busy` never high.
- Issue and reset corner cases:
  - Start MULT, then pulse `start` with MTLO (A = 0xAAAA) during `busy` → LO ends at the mult result; the MTLO is ignored.
  - Assert `reset` at `cnt` = 3 of a DIV → HI = LO = 0 and `busy` = 0 immediately, with no later commit.
- Edge operands:
  - 0x80000000 / 0xFFFFFFFF signed → LO = 0x80000000, HI = 0.
  - MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
